// File: rtl/systolic_skew_feeder_if.sv
// Stream bus between the operand fetch side and the systolic skew feeder.
// The master drives vectors in; the slave returns the skewed wavefront and block status.
interface systolic_skew_feeder_if #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic                    reverse;
    logic [N*DATA_WIDTH-1:0] in_data;
    logic [N*DATA_WIDTH-1:0] out_data;
    logic [N-1:0]            out_valid;
    logic                    busy;
    logic                    drain_done;

    modport master (
        output in_valid, in_last, reverse, in_data,
        input  in_ready, out_data, out_valid, busy, drain_done
    );

    modport slave (
        input  in_valid, in_last, reverse, in_data,
        output in_ready, out_data, out_valid, busy, drain_done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Input skew stage for an N x N systolic array: lane i is delayed by i advancing cycles,
// with per-lane valid bits, optional lane reversal per block and a self-draining tail.
module systolic_skew_feeder #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    systolic_skew_feeder_if.slave bus
);
    localparam int               CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N - 1);
    localparam int               LW       = DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_next_s;
    logic                    reverse_q_r;
    logic                    reverse_q_next_s;
    logic                    drain_done_r;
    logic                    drain_done_next_s;
    logic                    in_ready_s;
    logic                    busy_s;
    logic                    accept_s;
    logic                    rev_sel_s;
    logic [N*DATA_WIDTH-1:0] mapped_s;
    logic [N*DATA_WIDTH-1:0] out_data_s;
    logic [N-1:0]            out_valid_s;
    logic [LW-1:0]           lane_out_s [N];

    assign accept_s  = en & bus.in_valid & in_ready_s;
    // The first beat of a block uses the live reverse input; later beats use the latched copy.
    assign rev_sel_s = (state_r == ST_IDLE) ? bus.reverse : reverse_q_r;

    // State register: FSM state, drain counter, latched reversal and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            reverse_q_r  <= 1'b0;
            drain_done_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            reverse_q_r  <= reverse_q_next_s;
            drain_done_r <= drain_done_next_s;
        end
    end

    // Next-state logic; everything holds while en is low
    always_comb begin
        state_next_s      = state_r;
        cnt_next_s        = cnt_r;
        reverse_q_next_s  = reverse_q_r;
        drain_done_next_s = drain_done_r;
        if (en) begin
            drain_done_next_s = 1'b0;
            case (state_r)
                ST_IDLE, ST_STREAM: begin
                    if (accept_s) begin
                        if (state_r == ST_IDLE) begin
                            reverse_q_next_s = bus.reverse;
                        end else begin
                            reverse_q_next_s = reverse_q_r;
                        end
                        if (!bus.in_last) begin
                            state_next_s = ST_STREAM;
                        end else if (N == 1) begin
                            state_next_s      = ST_IDLE;
                            drain_done_next_s = 1'b1;
                        end else begin
                            // Pulse is timed to coincide with the last element leaving lane N-1.
                            state_next_s      = ST_DRAIN;
                            cnt_next_s        = CNT_LOAD;
                            drain_done_next_s = (N == 2);
                        end
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_DRAIN: begin
                    cnt_next_s        = cnt_r - CNT_W'(1);
                    drain_done_next_s = (cnt_r == CNT_W'(2));
                    if (cnt_r == CNT_W'(1)) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_DRAIN;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = '0;
                end
            endcase
        end else begin
            drain_done_next_s = drain_done_r;
        end
    end

    // Output decode from the current state
    always_comb begin
        in_ready_s = 1'b1;
        busy_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            ST_STREAM: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b1;
            end
            ST_DRAIN: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b1;
            end
            default: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
        endcase
    end

    // Lane-order mapping of the incoming vector
    always_comb begin
        mapped_s = '0;
        for (int j = 0; j < N; j++) begin
            if (rev_sel_s) begin
                mapped_s[DATA_WIDTH*(N-j)-1 -: DATA_WIDTH] = bus.in_data[DATA_WIDTH*(j+1)-1 -: DATA_WIDTH];
            end else begin
                mapped_s[DATA_WIDTH*(j+1)-1 -: DATA_WIDTH] = bus.in_data[DATA_WIDTH*(j+1)-1 -: DATA_WIDTH];
            end
        end
    end

    assign lane_out_s[0] = accept_s ? {mapped_s[DATA_WIDTH-1:0], 1'b1} : {LW{1'b0}};

    for (genvar i = 1; i < N; i++) begin : g_lane
        logic [LW-1:0] stage_r [i];

        // Delay chain of depth i; bubbles enter as zero data with valid low
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < i; k++) begin
                    stage_r[k] <= '0;
                end
            end else if (en) begin
                stage_r[0] <= accept_s ? {mapped_s[DATA_WIDTH*(i+1)-1 -: DATA_WIDTH], 1'b1} : {LW{1'b0}};
                for (int k = 1; k < i; k++) begin
                    stage_r[k] <= stage_r[k-1];
                end
            end
        end

        assign lane_out_s[i] = stage_r[i-1];
    end

    // Pack lane outputs onto the bus
    always_comb begin
        out_data_s  = '0;
        out_valid_s = '0;
        for (int i = 0; i < N; i++) begin
            out_data_s[DATA_WIDTH*(i+1)-1 -: DATA_WIDTH] = lane_out_s[i][LW-1:1];
            out_valid_s[i]                               = lane_out_s[i][0];
        end
    end

    assign bus.out_data   = out_data_s;
    assign bus.out_valid  = out_valid_s;
    assign bus.in_ready   = in_ready_s;
    assign bus.busy       = busy_s;
    assign bus.drain_done = drain_done_r;
endmodule
